// File: rtl/sirv_gnrl_stream_dnsz_if.sv
// rtl/sirv_gnrl_stream_dnsz_if.sv - valid/ready handshake bundle for the stream downsizer
interface sirv_gnrl_stream_dnsz_if #(
    parameter int IW = 32,
    parameter int OW = 8
);
    localparam int CW = $clog2(IW / OW);

    // Wide word side
    logic          i_vld;
    logic          i_rdy;
    logic [IW-1:0] i_dat;
    logic [CW-1:0] i_nbeat;

    // Narrow beat side
    logic          o_vld;
    logic          o_rdy;
    logic [OW-1:0] o_dat;
    logic          o_last;

    // Environment view: drives words in and accepts beats out
    modport master (
        output i_vld, i_dat, i_nbeat, o_rdy,
        input  i_rdy, o_vld, o_dat, o_last
    );

    // Downsizer view
    modport slave (
        input  i_vld, i_dat, i_nbeat, o_rdy,
        output i_rdy, o_vld, o_dat, o_last
    );
endinterface

// File: rtl/sirv_gnrl_stream_dnsz.sv
// rtl/sirv_gnrl_stream_dnsz.sv - registered valid/ready stream downsizer, LSB beat first
module sirv_gnrl_stream_dnsz #(
    parameter int IW        = 32,
    parameter int OW        = 8,
    parameter int CUT_READY = 0,
    parameter int MSKO      = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sirv_gnrl_stream_dnsz_if.slave  s
);
    localparam int RATIO = IW / OW;
    localparam int CW    = $clog2(RATIO);

    // EMPTY/BUSY is the holding-register occupancy bit; the encoding keeps o_vld
    // a direct flop output.
    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_t;

    state_t        state;
    logic          vld_r;
    logic [IW-1:0] dat_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] nbeat_r;
    logic [CW-1:0] nbeat_in;
    logic          last;
    logic          accept;
    logic          xfer;
    logic [OW-1:0] beat;

    assign vld_r  = (state == BUSY);
    assign last   = vld_r & (cnt_r == nbeat_r);
    assign xfer   = vld_r & s.o_rdy;
    assign accept = s.i_vld & s.i_rdy;

    // With CUT_READY the input side never looks at o_rdy, trading one bubble
    // per word for a shorter ready path.
    generate
        if (CUT_READY != 0) begin : g_cut_ready
            assign s.i_rdy = ~vld_r;
        end else begin : g_pass_ready
            assign s.i_rdy = ~vld_r | (s.o_rdy & last);
        end
    endgenerate

    // A beat count beyond the word can only be requested when RATIO is not a
    // power of two; clamp it so the counter never indexes past the word.
    generate
        if ((1 << CW) == RATIO) begin : g_nbeat_pow2
            assign nbeat_in = s.i_nbeat;
        end else begin : g_nbeat_clamp
            assign nbeat_in = (s.i_nbeat > CW'(RATIO - 1)) ? CW'(RATIO - 1) : s.i_nbeat;
        end
    endgenerate

    // Occupancy FSM with beat counter; a load overrides the last-beat drain so
    // back-to-back words stay BUSY without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            cnt_r   <= '0;
            nbeat_r <= '0;
        end else if (accept) begin
            state   <= BUSY;
            cnt_r   <= '0;
            nbeat_r <= nbeat_in;
        end else if (xfer) begin
            if (last) begin
                state <= EMPTY;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    // Word holding register; data path only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            dat_r <= s.i_dat;
        end
    end

    // Beat select from the registered word, decoded from flops only.
    always_comb begin
        beat = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (cnt_r == CW'(k)) begin
                beat = dat_r[k*OW +: OW];
            end
        end
    end

    assign s.o_vld  = vld_r;
    assign s.o_last = last;
    assign s.o_dat  = (MSKO != 0) ? (beat & {OW{vld_r}}) : beat;
endmodule

// File: doc/sirv_gnrl_stream_dnsz.md
# sirv_gnrl_stream_dnsz

Registered valid/ready stream downsizer. It accepts one IW-bit word per handshake and emits it as up to IW/OW narrower beats, least-significant beat first, with a last-beat flag. It sits on the read side of a general sync FIFO, between a wide FIFO output and a narrow consumer such as a byte-wide peripheral TX path. It uses the same valid/ready semantics as the rest of the general-purpose handshake library.

## Interface
- IW, 32, input word width; must be an integer multiple of OW.
- OW, 8, output beat width.
- CUT_READY, 0
  - 1: i_rdy depends only on local state; costs one idle cycle between words.
  - 0: i_rdy also depends on o_rdy.
- MSKO, 0, 1: o_dat forced to 0 whenever o_vld=0.
- Derived: RATIO=IW/OW (must be ≥2), CW=$clog2(RATIO).

- clk, in, 1, sole clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- i_vld, in, 1, input word valid.
- i_rdy, out, 1, input word ready.
- i_dat, in, IW, input word.
- i_nbeat, in, CW, number of beats to emit minus 1; sampled with i_dat.
- o_vld, out, 1, output beat valid.
- o_rdy, in, 1, output beat ready.
- o_dat, out, OW, output beat.
- o_last, out, 1, high on the final beat of the current word.

## Operation
- Accept rule: word accepted when i_vld & i_rdy. Beat transferred when o_vld & o_rdy.
- Internal state:
  - vld_r (1 bit): holding register occupied.
  - dat_r (IW): holding register.
  - cnt_r (CW): current beat index.
  - nbeat_r (CW): captured beat count minus 1.
- States:
  - EMPTY (vld_r=0): o_vld=0.
  - BUSY (vld_r=1): o_vld=1.
- On accept:
  - dat_r <= i_dat; cnt_r <= 0; vld_r <= 1.
  - nbeat_r <= min(i_nbeat, RATIO-1). Values ≥ RATIO are clamped, which only applies when RATIO is not a power of two.
- Outputs:
  - o_dat = dat_r[cnt_r*OW +: OW] (beat 0 = bits OW-1:0).
  - o_last = vld_r & (cnt_r == nbeat_r).
- Beat transferred, not last: cnt_r <= cnt_r+1; stay BUSY.
- Beat transferred, last:
  - If a new word is accepted in the same cycle (CUT_READY=0 only): load the new word; stay BUSY.
  - Otherwise: vld_r <= 0, go to EMPTY. cnt_r holds its value; only the next load resets it.
- i_rdy:
  - CUT_READY=1: i_rdy = ~vld_r.
  - CUT_READY=0: i_rdy = ~vld_r | (o_rdy & o_last).
- o_vld is taken directly from the vld_r flop (flop-clean); o_last and o_dat are decoded from flops only.
- No combinational path from i_* to o_*.
- dat_r is not reset.
- MSKO=1: o_dat = {OW{o_vld}} & selected beat. MSKO=0: o_dat is unmasked and may be X before the first load.
- If o_vld=1 and o_rdy=0, o_dat and o_last hold stable. o_vld does not drop until its beat transfers.
- Per-word beat count varies from 1 (i_nbeat=0) to RATIO.

## Timing
- Reset values: o_vld=0, o_last=0, i_rdy=1, cnt_r=0, nbeat_r=0; o_dat=0 when MSKO=1.
- Reset is asynchronous. Asserting reset mid-word discards the remaining beats; after release the block is EMPTY.
- Latency: word accepted at edge N gives its first beat valid in cycle N+1.
- Throughput with o_rdy held at 1:
  - CUT_READY=0: n+1 beats per word back-to-back; the next word's beat 0 follows the previous last beat with zero bubble.
  - CUT_READY=1: one idle o_vld=0 cycle between words, because i_rdy rises only in the cycle after the last beat.
- Back-pressure: o_rdy low stalls cnt_r; there is no beat loss and no duplication.
- i_vld dropping while i_rdy=0 has no effect. The block never samples i_dat without i_rdy.

## Test plan
- Reset, then single word:
  - Stimulus: IW=32, OW=8, i_dat=0x44332211, i_nbeat=3, o_rdy=1.
  - Required: beats 0x11, 0x22, 0x33, 0x44 in consecutive cycles starting one cycle after accept; o_last only on 0x44; o_vld=0 afterwards.
- Back-to-back words, CUT_READY=0:
  - Stimulus: words 0xDDCCBBAA then 0x87654321, o_rdy=1.
  - Required: 8 contiguous beats AA BB CC DD 21 43 65 87; i_rdy=1 in the cycle of beat DD.
- Same stimulus with CUT_READY=1:
  - Required: exactly one o_vld=0 cycle between DD and 21; i_rdy=0 throughout BUSY.
- Short words and clamp:
  - i_nbeat=0 with 0x000000F0 → single beat F0 with o_last=1.
  - i_nbeat=1 with 0x0000BEEF → EF then BE (last).
- Random o_rdy back-pressure with 100 random words and random i_nbeat:
  - Required: scoreboard sees every beat exactly once, in order.
  - Required: o_dat and o_last stable while o_vld & ~o_rdy.
  - Required: o_last count equals the accepted word count.
- Reset asserted after beat 1 of 4:
  - Required: o_vld=0 and o_last=0 immediately (asynchronously); i_rdy=1.
  - Required: the next word starts at beat 0, with o_dat=0 when MSKO=1 before that load.
